tinyalu_wide: RTL and testbench
===============================

TINYALU_WIDE -- requirements
Module: tinyalu_wide

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port A  input  WIDTH  operand A.
REQ-005 SHALL have port B  input  WIDTH  operand B.
REQ-006 SHALL have port op  input  3  opcode.
REQ-007 SHALL have port start  input  1  command request; a command is accepted on its rising level.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-009 SHALL have port busy  output  1  high while a command is in progress.
REQ-010 SHALL have port err  output  1  one-cycle pulse with done for an illegal opcode.
REQ-011 SHALL have port result  output  2*WIDTH  operation result, held between commands.

Function
REQ-012 SHALL use opcodes: no_op=0, add_op=1, and_op=2, xor_op=3, mul_op=4, sub_op=5, illegal=6, rst_op=7.
REQ-013 SHALL accept a command at a rising edge where start=1, the registered previous start=0, and state=IDLE; start held high yields exactly one command.
REQ-014 SHALL latch A, B and op at acceptance; later input changes do not affect the command.
REQ-015 SHALL ignore start edges while busy, while still updating the previous-start register.
REQ-016 SHALL implement FSM states IDLE, SINGLE, MULT and DONE: IDLE->SINGLE on acceptance of op 0,1,2,3,5,6; IDLE->MULT on mul_op; SINGLE->DONE after 1 cycle; MULT->DONE after WIDTH cycles; DONE->IDLE unconditionally.
REQ-017 SHALL drive done=1 for exactly the cycle spent in DONE, giving latency 2 edges for single-cycle ops and WIDTH+1 edges for mul_op, counted from the acceptance edge.
REQ-018 SHALL drive busy=1 in SINGLE, MULT and DONE, and busy=0 in IDLE.
REQ-019 SHALL compute add as zero-extended A+B, with carry in bit WIDTH.
REQ-020 SHALL compute and/xor as zero-extended bitwise results.
REQ-021 SHALL compute sub as zero-extended (A-B) mod 2^WIDTH, with bit WIDTH=1 exactly when A<B.
REQ-022 SHALL compute mul as the unsigned 2*WIDTH product using iterative shift-add, one partial product per cycle.
REQ-023 SHALL leave result unchanged for no_op, with done still pulsed.
REQ-024 SHALL, for opcode 6, leave result unchanged and pulse err together with done.
REQ-025 SHALL, on rst_op, clear result to 0 in IDLE and return to IDLE without entering SINGLE, leaving done, busy and err at 0.
REQ-026 SHALL update result only on the edge entering DONE, or on rst_op.

Reset
REQ-027 SHALL, on reset_n=0, immediately force: state=IDLE, result=0, done=0, busy=0, err=0, previous-start=0, multiplier counter and accumulator cleared.
REQ-028 SHALL abort any in-progress command on reset assertion, with no done pulse for it afterward.
REQ-029 SHALL accept a new command no earlier than the first rising edge after reset_n deasserts, and only with a fresh start rise.

Structure
REQ-030 SHALL place the operation_t enum (opcodes of REQ-012) and the FSM state enum in a shared package tinyalu_wide_pkg.
REQ-031 SHALL implement the multiplier as sub-module tinyalu_wide_mult, parametrised by WIDTH, with load, busy-count and product outputs.

Verification
REQ-032 SHALL verify, with WIDTH=8, that add A=255, B=1 gives result=0x0100 with done 2 edges after acceptance and err=0.
REQ-033 SHALL verify, with WIDTH=8, that mul A=255, B=255 gives result=0xFE01 with done 9 edges after acceptance and busy high throughout.
REQ-034 SHALL verify, with WIDTH=8, that sub A=3, B=5 gives result=0x01FE.
REQ-035 SHALL verify, with WIDTH=8, that op=6 after a prior result of 0x000F gives done=1 and err=1 in the same cycle, with result still 0x000F.
REQ-036 SHALL verify that reset_n pulsed low mid-mul gives result=0, busy=0 and no done; a subsequent xor A=0xF0, B=0xFF then gives 0x000F.
REQ-037 SHALL verify that start held high for 20 cycles with add A=1, B=2 gives exactly one done and result=0x0003.

Source files
------------

// File: rtl/tinyalu_wide_pkg.sv
// Shared opcode and controller-state types for the tinyalu_wide block.
package tinyalu_wide_pkg;

    typedef enum logic [2:0] {
        NO_OP      = 3'd0,
        ADD_OP     = 3'd1,
        AND_OP     = 3'd2,
        XOR_OP     = 3'd3,
        MUL_OP     = 3'd4,
        SUB_OP     = 3'd5,
        ILLEGAL_OP = 3'd6,
        RST_OP     = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_MULT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/tinyalu_wide_mult.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles after load.
module tinyalu_wide_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               last_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (load_i) begin
            cnt_q    <= CW'(WIDTH);
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (cnt_q != '0) begin
            cnt_q    <= cnt_q - 1'b1;
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

    assign busy_o    = (cnt_q != '0);
    // On the final step the completed product is the accumulator's next value.
    assign last_o    = (cnt_q == CW'(1));
    assign product_o = acc_d;

endmodule

// File: rtl/tinyalu_wide.sv
// Small sequenced ALU: single-cycle logic/arith ops plus a WIDTH-cycle multiply.
//   state    | meaning
//   S_IDLE   | waiting for a start rise; rst_op handled here
//   S_SINGLE | one-cycle op evaluating from latched operands
//   S_MULT   | multiplier stepping, WIDTH cycles
//   S_DONE   | result valid, done (and err) pulsed
module tinyalu_wide
    import tinyalu_wide_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    input  logic               start,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic [2*WIDTH-1:0] result
);

    state_t             state_q;
    operation_t         op_q;
    operation_t         op_in;
    logic               start_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH-1:0] alu_d;
    logic [WIDTH:0]     sub_w;
    logic               done_q;
    logic               busy_q;
    logic               err_q;
    logic               accept_w;
    logic               mult_busy_w;
    logic               mult_last_w;
    logic [2*WIDTH-1:0] mult_prod_w;

    assign op_in    = operation_t'(op);
    assign accept_w = start && !start_q && (state_q == S_IDLE);
    // Bit WIDTH of the widened difference is the borrow, set exactly when A < B.
    assign sub_w    = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        alu_d = result_q;
        case (op_q)
            ADD_OP:  alu_d = {{(WIDTH-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
            AND_OP:  alu_d = {{WIDTH{1'b0}}, a_q & b_q};
            XOR_OP:  alu_d = {{WIDTH{1'b0}}, a_q ^ b_q};
            SUB_OP:  alu_d = {{(WIDTH-1){1'b0}}, sub_w};
            default: alu_d = result_q;
        endcase
    end

    tinyalu_wide_mult #(.WIDTH(WIDTH)) u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (accept_w && (op_in == MUL_OP)),
        .a_i       (A),
        .b_i       (B),
        .busy_o    (mult_busy_w),
        .last_o    (mult_last_w),
        .product_o (mult_prod_w)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= NO_OP;
            start_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            start_q <= start;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_w) begin
                        a_q  <= A;
                        b_q  <= B;
                        op_q <= op_in;
                        if (op_in == RST_OP) begin
                            result_q <= '0;
                        end else if (op_in == MUL_OP) begin
                            state_q <= S_MULT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_SINGLE;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_SINGLE: begin
                    result_q <= alu_d;
                    err_q    <= (op_q == ILLEGAL_OP);
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_MULT: begin
                    // A multiplier that is no longer counting also ends the command.
                    if (mult_last_w || !mult_busy_w) begin
                        result_q <= mult_prod_w;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_tinyalu_wide.sv
// Randomised and directed checks of tinyalu_wide (WIDTH=8) against an arithmetic reference model.
module tb_tinyalu_wide;

    localparam int WIDTH = 8;

    logic               clk;
    logic               reset_n;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               done;
    logic               busy;
    logic               err;
    logic [2*WIDTH-1:0] result;

    int          n_cmp;
    int          n_mis;
    logic [15:0] mdl_result;

    tinyalu_wide #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .busy    (busy),
        .err     (err),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_result(input int o, input int a, input int b,
                                               input logic [15:0] prev);
        case (o)
            1:       return 16'(a + b);
            2:       return 16'(a & b);
            3:       return 16'(a ^ b);
            4:       return 16'(a * b);
            5:       return 16'(((a - b) & 255) + ((a < b) ? 256 : 0));
            7:       return 16'd0;
            default: return prev;
        endcase
    endfunction

    task automatic run_cmd(input int o, input int a, input int b);
        int          lat;
        logic [15:0] exp;
        exp = ref_result(o, a, b, mdl_result);
        @(negedge clk);
        A = 8'(a); B = 8'(b); op = 3'(o); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom); op = 3'($urandom);
        if (o == 7) begin
            chk("rstop_busy",   32'(busy),   32'd0);
            chk("rstop_done",   32'(done),   32'd0);
            chk("rstop_result", 32'(result), 32'd0);
            mdl_result = exp;
            @(posedge clk); #1;
            chk("rstop_done_after", 32'(done), 32'd0);
            return;
        end
        lat = (o == 4) ? WIDTH : 1;
        for (int k = 0; k < lat; k++) begin
            chk("busy_in_progress", 32'(busy), 32'd1);
            chk("done_early",       32'(done), 32'd0);
            @(posedge clk); #1;
        end
        chk("done_pulse",  32'(done),   32'd1);
        chk("busy_in_done", 32'(busy),  32'd1);
        chk("err_flag",    32'(err),    (o == 6) ? 32'd1 : 32'd0);
        chk("result",      32'(result), 32'(exp));
        mdl_result = exp;
        @(posedge clk); #1;
        chk("done_cleared", 32'(done), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
        chk("err_cleared",  32'(err),  32'd0);
        chk("result_held",  32'(result), 32'(exp));
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_mis = 0;
        mdl_result = '0;
        reset_n = 1'b0;
        A = '0; B = '0; op = '0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        chk("reset_err",    32'(err),    32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_cmd(1, 255, 1);
        chk("add_carry", 32'(result), 32'h0100);
        run_cmd(4, 255, 255);
        chk("mul_max", 32'(result), 32'hFE01);
        run_cmd(5, 3, 5);
        chk("sub_borrow", 32'(result), 32'h01FE);
        run_cmd(3, 8'hF0, 8'hFF);
        run_cmd(6, 8'h12, 8'h34);
        chk("illegal_keeps", 32'(result), 32'h000F);
        run_cmd(0, 8'h55, 8'hAA);
        chk("noop_keeps", 32'(result), 32'h000F);
        run_cmd(7, 0, 0);

        // Reset pulse in the middle of a multiply.
        run_cmd(1, 9, 9);
        @(negedge clk);
        A = 8'd200; B = 8'd100; op = 3'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midmul_result", 32'(result), 32'd0);
        chk("midmul_busy",   32'(busy),   32'd0);
        chk("midmul_done",   32'(done),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mdl_result = '0;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("midmul_no_done", 32'(cnt), 32'd0);
        run_cmd(3, 8'hF0, 8'hFF);
        chk("xor_after_reset", 32'(result), 32'h000F);

        // Start held high: exactly one command.
        @(negedge clk);
        A = 8'd1; B = 8'd2; op = 3'd1; start = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        chk("held_one_done", 32'(cnt), 32'd1);
        chk("held_result",   32'(result), 32'h0003);
        mdl_result = 16'h0003;

        for (int i = 0; i < 60; i++) begin
            run_cmd(int'($urandom_range(7, 0)), int'($urandom_range(255, 0)),
                    int'($urandom_range(255, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
